// File: rtl/bus_pkg.sv
// Shared types and constants for the two-core memory bus arbiter.
package bus_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 9;
  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} bus_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant handshake of both cores plus the gpiomem port, as seen by the arbiter.
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  logic              core0_request;
  logic              core0_grant;
  logic              core0_rw;
  logic [ADDR_W-1:0] core0_address;
  logic [DATA_W-1:0] core0_data_in;
  logic [DATA_W-1:0] core0_data_out;

  logic              core1_request;
  logic              core1_grant;
  logic              core1_rw;
  logic [ADDR_W-1:0] core1_address;
  logic [DATA_W-1:0] core1_data_in;
  logic [DATA_W-1:0] core1_data_out;

  logic [ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0] RAM_data_in;
  logic [DATA_W-1:0] RAM_data_out;
  logic              rw;

  modport slave (
    input  core0_request, core0_rw, core0_address, core0_data_in,
    output core0_grant, core0_data_out,
    input  core1_request, core1_rw, core1_address, core1_data_in,
    output core1_grant, core1_data_out,
    output RAM_address, RAM_data_in, rw,
    input  RAM_data_out
  );

  modport master (
    output core0_request, core0_rw, core0_address, core0_data_in,
    input  core0_grant, core0_data_out,
    output core1_request, core1_rw, core1_address, core1_data_in,
    input  core1_grant, core1_data_out,
    input  RAM_address, RAM_data_in, rw,
    output RAM_data_out
  );

endinterface

// File: rtl/tenure_counter.sv
// Counts consecutive granted cycles of the current owner; saturates at the tenure limit.
module tenure_counter #(
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  localparam int unsigned LIMIT = (MAX_TENURE == 0) ? 0 : MAX_TENURE - 1;
  localparam int          CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(LIMIT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // Holding at LIMIT lets a late-arriving waiter preempt at the end of its first waiting cycle.
  assign at_limit = (MAX_TENURE != 0) && (count == CNT_W'(LIMIT));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting core0/core1 access to gpiomem, with optional tenure preemption.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus,
  output logic         owner,
  output logic         busy
);

  bus_state_t        state;
  bus_state_t        next_state;
  logic              at_limit;
  logic              tenure_clear;
  logic              tenure_enable;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              prev_grant0;
  logic              prev_grant1;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        if (next_state == GRANT0) owner <= 1'b0;
        else if (next_state == GRANT1) owner <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.core0_request && bus.core1_request) next_state = owner ? GRANT0 : GRANT1;
        else if (bus.core0_request)                 next_state = GRANT0;
        else if (bus.core1_request)                 next_state = GRANT1;
      end
      GRANT0: begin
        if (!bus.core0_request)                   next_state = bus.core1_request ? GRANT1 : IDLE;
        else if (bus.core1_request && at_limit)   next_state = GRANT1;
      end
      GRANT1: begin
        if (!bus.core1_request)                   next_state = bus.core0_request ? GRANT0 : IDLE;
        else if (bus.core0_request && at_limit)   next_state = GRANT0;
      end
      default: next_state = IDLE;
    endcase
  end

  assign tenure_clear  = (next_state != state);
  assign tenure_enable = (state != IDLE);

  tenure_counter #(
    .MAX_TENURE(MAX_TENURE)
  ) u_tenure (
    .clk     (clk),
    .reset   (reset),
    .clear   (tenure_clear),
    .enable  (tenure_enable),
    .at_limit(at_limit)
  );

  // Write enable is gated by request so the release cycle can never issue a write.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    bus.rw    = RW_READ;
    unique case (state)
      GRANT0: begin
        addr_mux  = bus.core0_address;
        wdata_mux = bus.core0_data_in;
        bus.rw    = (bus.core0_rw == RW_WRITE) && bus.core0_request;
      end
      GRANT1: begin
        addr_mux  = bus.core1_address;
        wdata_mux = bus.core1_data_in;
        bus.rw    = (bus.core1_rw == RW_WRITE) && bus.core1_request;
      end
      default: ;
    endcase
  end

  assign bus.RAM_address = addr_mux;
  assign bus.RAM_data_in = wdata_mux;

  assign bus.core0_grant = (state == GRANT0);
  assign bus.core1_grant = (state == GRANT1);
  assign busy            = bus.core0_grant | bus.core1_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_grant0 <= 1'b0;
      prev_grant1 <= 1'b0;
      hold0       <= '0;
      hold1       <= '0;
    end else begin
      prev_grant0 <= bus.core0_grant;
      prev_grant1 <= bus.core1_grant;
      hold0       <= bus.core0_data_out;
      hold1       <= bus.core1_data_out;
    end
  end

  // gpiomem read data is already registered, so it is forwarded combinationally one cycle behind the grant.
  assign bus.core0_data_out = prev_grant0 ? bus.RAM_data_out : hold0;
  assign bus.core1_data_out = prev_grant1 ? bus.RAM_data_out : hold1;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed checks of bus_arbiter against a cycle-level reference model.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned MT = 4;
  localparam int unsigned MEM_WORDS = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  logic owner;
  logic busy;
  logic mem_init;

  logic          req [2];
  logic          rwi [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] din [2];

  int checks   = 0;
  int failures = 0;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_TENURE(MT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .owner(owner),
    .busy (busy)
  );

  always #5 clk = ~clk;

  assign bus.core0_request = req[0];
  assign bus.core0_rw      = rwi[0];
  assign bus.core0_address = adr[0];
  assign bus.core0_data_in = din[0];
  assign bus.core1_request = req[1];
  assign bus.core1_rw      = rwi[1];
  assign bus.core1_address = adr[1];
  assign bus.core1_data_in = din[1];

  // gpiomem stand-in: registered read, write on rw
  logic [DW-1:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= DW'(i * 7 + 3);
      bus.RAM_data_out <= '0;
    end else begin
      bus.RAM_data_out <= mem[bus.RAM_address];
      if (bus.rw) mem[bus.RAM_address] <= bus.RAM_data_in;
    end
  end

  // reference model
  int            m_hold;
  int            m_prev;
  int            m_cnt;
  int            m_owner;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_out [2];
  logic [DW-1:0] ref_mem [MEM_WORDS];

  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic          e_rw;
  logic [DW-1:0] e_out [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold  = -1;
    m_prev  = -1;
    m_cnt   = 0;
    m_owner = 1;
    m_rd    = '0;
    m_out[0] = '0;
    m_out[1] = '0;
  endtask

  task automatic compute_expect();
    e_addr = '0;
    e_din  = '0;
    e_rw   = 1'b0;
    if (m_hold >= 0) begin
      e_addr = adr[m_hold];
      e_din  = din[m_hold];
      e_rw   = rwi[m_hold] & req[m_hold];
    end
    for (int n = 0; n < 2; n++) e_out[n] = (m_prev == n) ? m_rd : m_out[n];
  endtask

  task automatic check_outputs();
    compute_expect();
    check_val("grant0",   32'(bus.core0_grant), 32'(m_hold == 0));
    check_val("grant1",   32'(bus.core1_grant), 32'(m_hold == 1));
    check_val("excl",     32'(bus.core0_grant & bus.core1_grant), 32'd0);
    check_val("owner",    32'(owner), 32'(m_owner));
    check_val("busy",     32'(busy), 32'(m_hold >= 0));
    check_val("ram_addr", 32'(bus.RAM_address), 32'(e_addr));
    check_val("ram_din",  32'(bus.RAM_data_in), 32'(e_din));
    check_val("rw",       32'(bus.rw), 32'(e_rw));
    check_val("dout0",    32'(bus.core0_data_out), 32'(e_out[0]));
    check_val("dout1",    32'(bus.core1_data_out), 32'(e_out[1]));
  endtask

  task automatic model_edge();
    int            nxt;
    int            o;
    int            held;
    logic [DW-1:0] new_rd;
    if (reset) begin
      model_reset();
      return;
    end
    compute_expect();
    m_out[0] = e_out[0];
    m_out[1] = e_out[1];
    new_rd = ref_mem[e_addr];
    if (e_rw) ref_mem[e_addr] = e_din;
    held = (m_hold >= 0) ? m_cnt + 1 : 0;
    if (m_hold < 0) begin
      if (req[0] && req[1]) nxt = (m_owner == 1) ? 0 : 1;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
    end else begin
      o = 1 - m_hold;
      if (!req[m_hold])                          nxt = req[o] ? o : -1;
      else if (req[o] && MT != 0 && held >= MT)  nxt = o;
      else                                       nxt = m_hold;
    end
    m_cnt = (nxt == m_hold) ? held : 0;
    if (nxt >= 0 && nxt != m_hold) m_owner = nxt;
    m_prev = m_hold;
    m_hold = nxt;
    m_rd   = new_rd;
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic drive(input int c, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c] = r;
    rwi[c] = w;
    adr[c] = a;
    din[c] = d;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_val("rst_grant0", 32'(bus.core0_grant), 32'd0);
    check_val("rst_grant1", 32'(bus.core1_grant), 32'd0);
    check_val("rst_rw",     32'(bus.rw), 32'd0);
    check_val("rst_busy",   32'(busy), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] pre;
    reset    = 1'b1;
    mem_init = 1'b1;
    for (int c = 0; c < 2; c++) drive(c, 1'b0, RW_READ, '0, '0);
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = DW'(i * 7 + 3);
    model_reset();
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    step(2);

    // first grant after reset, write then read back
    reset = 1'b0;
    drive(0, 1'b1, RW_WRITE, 9'h010, 8'hA5);
    step(1);
    step(1);
    drive(0, 1'b1, RW_READ, 9'h010, 8'h00);
    step(1);
    drive(0, 1'b1, RW_READ, 9'h011, 8'h00);
    step(1);
    check_val("wr_mem", 32'(mem[9'h010]), 32'h000000A5);
    drive(0, 1'b0, RW_READ, 9'h000, 8'h00);
    step(3);

    // simultaneous requests from reset, then hand-over with no dead cycle
    async_reset();
    step(1);
    reset = 1'b0;
    drive(0, 1'b1, RW_READ, 9'h004, 8'h00);
    drive(1, 1'b1, RW_READ, 9'h005, 8'h00);
    step(3);
    drive(0, 1'b0, RW_READ, 9'h000, 8'h00);
    step(3);
    drive(1, 1'b0, RW_READ, 9'h000, 8'h00);
    step(2);

    // tenure preemption and regrant
    drive(0, 1'b1, RW_READ, 9'h006, 8'h00);
    step(2);
    drive(1, 1'b1, RW_READ, 9'h007, 8'h00);
    step(9);
    drive(1, 1'b0, RW_READ, 9'h000, 8'h00);
    step(3);
    drive(0, 1'b0, RW_READ, 9'h000, 8'h00);
    step(2);

    // release with write still driven must not write
    drive(0, 1'b1, RW_READ, 9'h020, 8'h00);
    step(2);
    pre = ref_mem[9'h020];
    drive(0, 1'b0, RW_WRITE, 9'h020, 8'h3C);
    step(2);
    check_val("rel_mem", 32'(mem[9'h020]), 32'(pre));
    drive(0, 1'b0, RW_READ, 9'h000, 8'h00);
    step(1);

    // reset while core1 is writing
    drive(1, 1'b1, RW_WRITE, 9'h030, 8'h77);
    step(3);
    drive(1, 1'b1, RW_WRITE, 9'h030, 8'h99);
    async_reset();
    step(2);
    check_val("rst_mem", 32'(mem[9'h030]), 32'h00000077);
    reset = 1'b0;
    drive(0, 1'b1, RW_READ, 9'h030, 8'h00);
    drive(1, 1'b1, RW_READ, 9'h031, 8'h00);
    step(4);
    drive(0, 1'b0, RW_READ, 9'h000, 8'h00);
    drive(1, 1'b0, RW_READ, 9'h000, 8'h00);
    step(2);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        logic r;
        r = req[c];
        if ($urandom_range(0, 5) == 0) r = ~r;
        drive(c, r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        step(1);
        reset = 1'b0;
      end
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
